// File: rtl/dmem_access_ctrl.sv
// Sequencer between the MEM stage and a word-wide data memory: sub-word loads
// with extension, sub-word stores by read-modify-write, and access checking.
module dmem_access_ctrl #(
  parameter int unsigned MEM_BYTES = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic        err,
  output logic [31:0] rdata,
  output logic        busy,
  output logic [31:0] mem_A,
  output logic [31:0] mem_WD,
  output logic        mem_WE,
  input  logic [31:0] mem_RD
);

  // Handshake: req is sampled only at an edge where the FSM is IDLE; the access
  // finishes with a single-cycle ack (err qualifies it); busy is high otherwise.
  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

  localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

  state_t      state_q, state_d;
  logic        r_we, r_sext, err_q;
  logic [1:0]  r_size;
  logic [31:0] r_addr, r_wdata, merge_q, rdata_q;
  logic        req_err;
  logic [31:0] lane_word, load_ext, merged;

  always_comb begin
    req_err = (size == 2'b11)
            | ((size == 2'b01) & addr[0])
            | ((size == 2'b10) & (addr[1:0] != 2'b00))
            | ({1'b0, addr} >= MEM_LIMIT);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (req_err)                     state_d = S_DONE;
          else if (!we || size != 2'b10)   state_d = S_RD;
          else                             state_d = S_WR;
        end
      end
      S_RD:    state_d = r_we ? S_WR : S_DONE;
      S_WR:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Lane extraction and merge operate on the word currently returned by memory.
  always_comb begin
    lane_word = mem_RD >> {r_addr[1:0], 3'b000};
    load_ext  = mem_RD;
    merged    = mem_RD;
    case (r_size)
      2'b00: begin
        load_ext = {{24{r_sext & lane_word[7]}}, lane_word[7:0]};
        merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
      end
      2'b01: begin
        load_ext = {{16{r_sext & lane_word[15]}}, lane_word[15:0]};
        merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
      end
      default: begin
        load_ext = mem_RD;
        merged   = mem_RD;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_sext  <= 1'b0;
      r_size  <= 2'b00;
      r_addr  <= '0;
      r_wdata <= '0;
      err_q   <= 1'b0;
      merge_q <= '0;
      rdata_q <= '0;
    end else begin
      if (state_q == S_IDLE && req) begin
        r_we    <= we;
        r_sext  <= sign_ext;
        r_size  <= size;
        r_addr  <= addr;
        r_wdata <= wdata;
        err_q   <= req_err;
      end
      if (state_q == S_RD) begin
        if (r_we) merge_q <= merged;
        else      rdata_q <= load_ext;
      end
    end
  end

  // Outputs decode registered state only, so rst removes mem_WE at once.
  always_comb begin
    ack    = (state_q == S_DONE);
    err    = (state_q == S_DONE) & err_q;
    busy   = (state_q != S_IDLE);
    mem_WE = (state_q == S_WR);
    mem_A  = '0;
    mem_WD = '0;
    if (state_q == S_RD || state_q == S_WR) mem_A = {r_addr[31:2], 2'b00};
    if (state_q == S_WR) mem_WD = (r_size == 2'b10) ? r_wdata : merge_q;
    rdata  = rdata_q;
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a small word memory model.
module tb_dmem_access_ctrl;

  logic        clk, rst;
  logic        req, we, sign_ext;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        ack, err, busy, mem_WE;
  logic [31:0] rdata, mem_A, mem_WD, mem_RD;

  logic [31:0] mem [0:63];
  int n_cmp, n_fail;

  dmem_access_ctrl #(.MEM_BYTES(65536)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .ack(ack), .err(err), .rdata(rdata), .busy(busy),
    .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD)
  );

  // Clock / memory model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (mem_WE) mem[mem_A[7:2]] <= mem_WD;
  assign mem_RD = mem[mem_A[7:2]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Driver: issue one request from IDLE, return latency (edges from accept to
  // visible ack), err, rdata and number of cycles with mem_WE high.
  task automatic do_access(input logic w, input logic [1:0] sz, input logic sx,
                           input logic [31:0] a, input logic [31:0] wd,
                           output int lat, output logic e, output logic [31:0] rd,
                           output int wes);
    int i;
    we = w; size = sz; sign_ext = sx; addr = a; wdata = wd; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0; we = 1'($urandom_range(0, 1)); size = 2'($urandom_range(0, 3));
    addr = $urandom(); wdata = $urandom(); sign_ext = 1'($urandom_range(0, 1));
    lat = 0; wes = 0; e = 1'b0; rd = '0; i = 0;
    while (lat == 0 && i < 8) begin
      i++;
      @(negedge clk);
      if (mem_WE) wes++;
      if (ack) begin
        lat = i; e = err; rd = rdata;
      end else begin
        @(posedge clk);
      end
    end
    if (lat == 0) check("ack_timeout", {31'b0, ack}, 32'd1);
    @(negedge clk);
  endtask

  task automatic access_chk(input string tag, input logic w, input logic [1:0] sz,
                            input logic sx, input logic [31:0] a, input logic [31:0] wd,
                            input int exp_lat, input logic exp_err, input int exp_wes,
                            output logic [31:0] rd);
    int lat, wes;
    logic e;
    do_access(w, sz, sx, a, wd, lat, e, rd, wes);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_err"}, {31'b0, e}, {31'b0, exp_err});
    check({tag, "_we"}, 32'(wes), 32'(exp_wes));
  endtask

  initial begin
    logic [31:0] rd;
    int acks, ack_cyc [2];
    logic [31:0] ack_rd [2];
    n_cmp = 0; n_fail = 0;
    req = 0; we = 0; size = 0; sign_ext = 0; addr = 0; wdata = 0;

    // Reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ack", {31'b0, ack}, 0);
    check("rst_err", {31'b0, err}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_we", {31'b0, mem_WE}, 0);
    check("rst_rdata", rdata, 0);
    check("rst_mem_a", mem_A, 0);
    check("rst_mem_wd", mem_WD, 0);
    rst = 1'b0;
    @(negedge clk);

    // Word store / load
    access_chk("sw10", 1, 2'b10, 0, 32'h10, 32'h11223344, 2, 0, 1, rd);
    check("sw10_mem", mem[4], 32'h11223344);
    access_chk("lw10", 0, 2'b10, 1, 32'h10, 32'h0, 2, 0, 0, rd);
    check("lw10_rd", rd, 32'h11223344);

    // Byte store (upper wdata bits must be ignored)
    access_chk("sb12", 1, 2'b00, 0, 32'h12, 32'h555555AB, 3, 0, 1, rd);
    check("sb12_mem", mem[4], 32'h11AB3344);
    check("sb12_rdata_held", rdata, 32'h11223344);

    access_chk("lb12s", 0, 2'b00, 1, 32'h12, 32'h0, 2, 0, 0, rd);
    check("lb12s_rd", rd, 32'hFFFFFFAB);
    access_chk("lb12u", 0, 2'b00, 0, 32'h12, 32'h0, 2, 0, 0, rd);
    check("lb12u_rd", rd, 32'h000000AB);
    access_chk("lh12s", 0, 2'b01, 1, 32'h12, 32'h0, 2, 0, 0, rd);
    check("lh12s_rd", rd, 32'h000011AB);
    access_chk("lb13u", 0, 2'b00, 0, 32'h13, 32'h0, 2, 0, 0, rd);
    check("lb13u_rd", rd, 32'h00000011);
    access_chk("lh10s", 0, 2'b01, 1, 32'h10, 32'h0, 2, 0, 0, rd);
    check("lh10s_rd", rd, 32'h00003344);

    // Errors: memory and rdata stay untouched
    access_chk("e_h13", 0, 2'b01, 1, 32'h13, 32'h0, 1, 1, 0, rd);
    access_chk("e_w12", 1, 2'b10, 0, 32'h12, 32'hDEADBEEF, 1, 1, 0, rd);
    access_chk("e_sz3", 1, 2'b11, 0, 32'h10, 32'hDEADBEEF, 1, 1, 0, rd);
    access_chk("e_oor", 0, 2'b10, 0, 32'h10000, 32'h0, 1, 1, 0, rd);
    access_chk("e_oors", 1, 2'b00, 0, 32'h10010, 32'h0, 1, 1, 0, rd);
    check("err_mem", mem[4], 32'h11AB3344);
    check("err_rdata", rdata, 32'h00003344);

    // Reset during WR of a byte store
    we = 1; size = 2'b00; sign_ext = 0; addr = 32'h12; wdata = 32'h00000077; req = 1;
    @(posedge clk); #1 req = 0;
    @(posedge clk); #2;
    check("rst_mid_pre_we", {31'b0, mem_WE}, 1);
    check("rst_mid_pre_a", mem_A, 32'h10);
    rst = 1'b1; #1;
    check("rst_mid_we", {31'b0, mem_WE}, 0);
    check("rst_mid_busy", {31'b0, busy}, 0);
    check("rst_mid_ack", {31'b0, ack}, 0);
    @(posedge clk); @(negedge clk);
    check("rst_mid_ack2", {31'b0, ack}, 0);
    check("rst_mid_mem", mem[4], 32'h11AB3344);
    rst = 1'b0;
    @(negedge clk);
    access_chk("post_rst", 0, 2'b10, 0, 32'h10, 32'h0, 2, 0, 0, rd);
    check("post_rst_rd", rd, 32'h11AB3344);

    // Halfword store and further extension cases
    access_chk("sh10", 1, 2'b01, 0, 32'h10, 32'h1234BEEF, 3, 0, 1, rd);
    check("sh10_mem", mem[4], 32'h11ABBEEF);
    access_chk("lh10s2", 0, 2'b01, 1, 32'h10, 32'h0, 2, 0, 0, rd);
    check("lh10s2_rd", rd, 32'hFFFFBEEF);
    access_chk("lb11s", 0, 2'b00, 1, 32'h11, 32'h0, 2, 0, 0, rd);
    check("lb11s_rd", rd, 32'hFFFFFFBE);
    access_chk("sw14", 1, 2'b10, 0, 32'h14, 32'hCAFEF00D, 2, 0, 1, rd);
    check("sw14_mem", mem[5], 32'hCAFEF00D);

    // req held high across a load: next address accepted at first IDLE edge
    we = 0; size = 2'b10; sign_ext = 0; addr = 32'h10; req = 1;
    @(posedge clk); #1 addr = 32'h14;
    acks = 0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      if (c == 3) #1 req = 0;
      @(negedge clk);
      if (c == 2) check("b2b_idle_busy", {31'b0, busy}, 0);
      if (ack) begin
        if (acks < 2) begin
          ack_cyc[acks] = c;
          ack_rd[acks] = rdata;
        end
        acks++;
      end
    end
    check("b2b_acks", 32'(acks), 2);
    if (acks >= 2) begin
      check("b2b_ack0_cyc", 32'(ack_cyc[0]), 1);
      check("b2b_ack0_rd", ack_rd[0], 32'h11ABBEEF);
      check("b2b_ack1_cyc", 32'(ack_cyc[1]), 4);
      check("b2b_ack1_rd", ack_rd[1], 32'hCAFEF00D);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
